// File: rtl/ahb_led_blinker_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the LED blinker slave.
interface ahb_led_blinker_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_led_blinker.sv
// Zero-wait-state AHB-Lite slave driving LED pins with static levels and
// per-LED blinking timed by a programmable prescaler.
module ahb_led_blinker #(
    parameter int unsigned NUM_LED   = 8,
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned DIV_RESET = 4999999
) (
    input  logic                CLK,
    input  logic                RESET,
    ahb_led_blinker_if.slave    bus,
    output logic [NUM_LED-1:0]  LED
);

    localparam int unsigned TICK_WIDTH = 16;
    localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(DIV_RESET);

    localparam logic [1:0] ADDR_LED_OUT   = 2'd0;
    localparam logic [1:0] ADDR_BLINK_EN  = 2'd1;
    localparam logic [1:0] ADDR_BLINK_DIV = 2'd2;
    localparam logic [1:0] ADDR_TICKCNT   = 2'd3;

    // Pipelined address-phase capture
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [1:0]            r_addr;
    logic                  r_size_ok;

    // Software-visible registers
    logic [NUM_LED-1:0]    r_led_out;
    logic [NUM_LED-1:0]    r_blink_en;
    logic [DIV_WIDTH-1:0]  r_blink_div;
    logic [TICK_WIDTH-1:0] r_tickcnt;

    // Prescaler state and output register
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic                  r_phase;
    logic [NUM_LED-1:0]    r_led;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_tick;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_commit = r_wr_en & r_size_ok;
    assign w_tick   = (r_cnt == '0);

    // Only HADDR[3:2], HTRANS[1] and the low HWDATA bits carry meaning here
    assign w_unused = ^{bus.HADDR, bus.HTRANS, bus.HWDATA};

    // Address phase capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= 2'd0;
            r_size_ok <= 1'b0;
        end else begin
            r_wr_en <= w_accept & bus.HWRITE;
            r_rd_en <= w_accept & ~bus.HWRITE;
            if (w_accept) begin
                r_addr    <= bus.HADDR[3:2];
                r_size_ok <= (bus.HSIZE == 3'b010);
            end
        end
    end

    // Static registers committed at the end of a word write data phase
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_led_out  <= '0;
            r_blink_en <= '0;
        end else if (w_commit) begin
            if (r_addr == ADDR_LED_OUT) begin
                r_led_out <= bus.HWDATA[NUM_LED-1:0];
            end
            if (r_addr == ADDR_BLINK_EN) begin
                r_blink_en <= bus.HWDATA[NUM_LED-1:0];
            end
        end
    end

    // Prescaler; a divider write reloads the counter, a tick-count write beats a same-cycle toggle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_blink_div <= DIV_INIT;
            r_cnt       <= DIV_INIT;
            r_phase     <= 1'b0;
            r_tickcnt   <= '0;
        end else begin
            if (w_tick) begin
                r_cnt     <= r_blink_div;
                r_phase   <= ~r_phase;
                r_tickcnt <= r_tickcnt + TICK_WIDTH'(1);
            end else begin
                r_cnt <= r_cnt - DIV_WIDTH'(1);
            end
            if (w_commit && (r_addr == ADDR_BLINK_DIV)) begin
                r_blink_div <= bus.HWDATA[DIV_WIDTH-1:0];
                r_cnt       <= bus.HWDATA[DIV_WIDTH-1:0];
            end
            if (w_commit && (r_addr == ADDR_TICKCNT)) begin
                r_tickcnt <= '0;
            end
        end
    end

    // LED drive
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_led <= '0;
        end else begin
            r_led <= (r_led_out & ~r_blink_en) |
                     (r_led_out & r_blink_en & {NUM_LED{r_phase}});
        end
    end

    // Read mux from the registered address, zero outside a read data phase
    always_comb begin
        w_rdata = 32'd0;
        if (r_rd_en) begin
            case (r_addr)
                ADDR_LED_OUT:   w_rdata = 32'(r_led_out);
                ADDR_BLINK_EN:  w_rdata = 32'(r_blink_en);
                ADDR_BLINK_DIV: w_rdata = 32'(r_blink_div);
                default:        w_rdata = 32'(r_tickcnt);
            endcase
        end
    end

    assign bus.HRDATA    = w_rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign LED           = r_led;

endmodule

// File: tb/tb_ahb_led_blinker.sv
// Randomised bench for ahb_led_blinker: a time-based reference model feeds a
// read-data scoreboard queue, and a negedge monitor checks HRDATA, LED and bus status.
module tb_ahb_led_blinker;

    localparam int unsigned NUM_LED   = 8;
    localparam int unsigned DIV_WIDTH = 24;
    localparam int unsigned DIV_RESET = 37;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_LED-1:0] led;

    ahb_led_blinker_if bus ();

    ahb_led_blinker #(
        .NUM_LED   (NUM_LED),
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_RESET (DIV_RESET)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave),
        .LED   (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: prescaler expressed as elapsed-edge arithmetic since the last reload
    longint               cyc = 0;
    longint               m_base;
    logic                 m_phase0;
    logic [15:0]          m_tick0;
    logic [DIV_WIDTH-1:0] m_div;
    logic [NUM_LED-1:0]   m_led_out, m_blink, m_led;
    logic                 m_valid = 1'b0;
    logic                 m_wr_pend = 1'b0, m_rd_dp = 1'b0, m_psize_ok = 1'b0;
    logic [1:0]           m_paddr;
    logic [31:0]          exp_q[$];

    function automatic longint toggles(input longint e);
        return (e - m_base) / (longint'(m_div) + 64'sd1);
    endfunction

    function automatic logic phase_at(input longint e);
        longint t;
        t = toggles(e);
        return m_phase0 ^ t[0];
    endfunction

    function automatic logic [15:0] tick_at(input longint e);
        return 16'(longint'(m_tick0) + toggles(e));
    endfunction

    function automatic logic [31:0] read_val(input longint e, input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_led_out);
            2'd1:    return 32'(m_blink);
            2'd2:    return 32'(m_div);
            default: return 32'(tick_at(e));
        endcase
    endfunction

    function automatic void commit(input longint e, input logic [1:0] a, input logic [31:0] d);
        logic        p;
        logic [15:0] tk;
        longint      t;
        case (a)
            2'd0: m_led_out = d[NUM_LED-1:0];
            2'd1: m_blink   = d[NUM_LED-1:0];
            2'd2: begin
                p = phase_at(e);
                tk = tick_at(e);
                m_base = e; m_phase0 = p; m_tick0 = tk;
                m_div = d[DIV_WIDTH-1:0];
            end
            default: begin
                t = toggles(e);
                m_tick0 = 16'(65536 - (t % 65536));
            end
        endcase
    endfunction

    always @(posedge clk) begin
        logic acc;
        logic ph;
        cyc++;
        if (rst) begin
            m_valid = 1'b1;
            m_base = cyc; m_phase0 = 1'b0; m_tick0 = '0; m_div = DIV_WIDTH'(DIV_RESET);
            m_led_out = '0; m_blink = '0; m_led = '0;
            m_wr_pend = 1'b0; m_rd_dp = 1'b0;
            exp_q.delete();
        end else if (m_valid) begin
            ph = phase_at(cyc - 1);
            for (int i = 0; i < NUM_LED; i++)
                m_led[i] = m_blink[i] ? (m_led_out[i] && ph) : m_led_out[i];
            if (m_wr_pend && m_psize_ok) commit(cyc, m_paddr, bus.HWDATA);
            acc = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
            m_rd_dp = acc && !bus.HWRITE;
            if (m_rd_dp) exp_q.push_back(read_val(cyc, bus.HADDR[3:2]));
            m_wr_pend = acc && bus.HWRITE;
            if (acc) begin
                m_paddr = bus.HADDR[3:2];
                m_psize_ok = (bus.HSIZE == 3'b010);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle
    always @(negedge clk) begin
        if (m_valid) begin
            check("LED", 32'(led), 32'(m_led));
            check("HREADYOUT", 32'(bus.HREADYOUT), 32'd1);
            check("HRESP", 32'(bus.HRESP), 32'd0);
            if (m_rd_dp) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL HRDATA_q: got 0x%08h with no expected entry", bus.HRDATA);
                end else begin
                    check("HRDATA", bus.HRDATA, exp_q.pop_front());
                end
            end else begin
                check("HRDATA_idle", bus.HRDATA, 32'd0);
            end
        end
    end

    // Stimulus
    logic [31:0] pend_data = 32'd0;

    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [3:0] addr, input logic [2:0] size,
                         input logic [31:0] data, input logic rdy);
        @(posedge clk);
        #1;
        bus.HWDATA = pend_data;
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HADDR  = {28'($urandom), addr[3:2], 2'b00};
        bus.HSIZE  = size;
        bus.HREADY = rdy;
        pend_data  = (sel && trans[1] && wr && rdy) ? data : $urandom;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        issue(1'b1, 2'b10, 1'b1, addr, 3'b010, data, 1'b1);
    endtask

    task automatic rd(input logic [3:0] addr);
        issue(1'b1, 2'b10, 1'b0, addr, 3'b010, $urandom, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, $urandom, 1'b1);
    endtask

    // Holds RESET for n edges; a pending write's data stays on HWDATA so it gets aborted
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.HWDATA = pend_data;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HREADY = 1'b1;
        pend_data = $urandom;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [3:0]  ad;
        logic [31:0] dt;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'b010; bus.HWDATA = '0; bus.HREADY = 1'b1;

        // Reset, then divider reads back its reset value
        do_reset(2);
        check("led_after_reset", 32'(led), 32'd0);
        rd(4'h8);
        idle(2);

        // Static level write then back-to-back read
        wr(4'h0, 32'h0000_00A5);
        rd(4'h0);
        idle(2);
        check("led_static_a5", 32'(led), 32'hA5);

        // Blinking low nibble with divider 3
        wr(4'h8, 32'd3);
        wr(4'h4, 32'h0F);
        wr(4'h0, 32'hFF);
        idle(20);
        for (int i = 0; i < 6; i++) begin
            rd(4'hC);
            idle(2);
        end
        rd(4'h4);
        rd(4'h8);

        // Byte write dropped, unselected and IDLE writes ignored
        issue(1'b1, 2'b10, 1'b1, 4'h0, 3'b000, 32'h3C, 1'b1);
        rd(4'h0);
        issue(1'b0, 2'b10, 1'b1, 4'h0, 3'b010, 32'h11, 1'b1);
        issue(1'b1, 2'b00, 1'b1, 4'h0, 3'b010, 32'h22, 1'b1);
        issue(1'b1, 2'b10, 1'b1, 4'h0, 3'b010, 32'h33, 1'b0);
        rd(4'h0);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            ad = 4'($urandom_range(0, 3) * 4);
            tr = 2'($urandom_range(0, 3));
            sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
            dt = (ad == 4'h8) ? 32'($urandom_range(0, 6)) : $urandom;
            issue(($urandom_range(0, 9) != 0), tr, 1'($urandom), ad, sz, dt,
                  ($urandom_range(0, 9) != 0));
        end
        idle(3);

        // TICKCNT wrap with a divider of zero
        wr(4'h4, 32'h0F);
        wr(4'h8, 32'd0);
        wr(4'hC, 32'd0);
        idle(65528);
        for (int i = 0; i < 12; i++) rd(4'hC);
        // A clear that coincides with a toggle reads back as zero
        wr(4'hC, 32'h1234);
        rd(4'hC);
        idle(2);

        // Reset during a write data phase aborts the write
        wr(4'h0, 32'h55);
        do_reset(1);
        check("led_after_abort", 32'(led), 32'd0);
        rd(4'h0);
        rd(4'h8);
        rd(4'hC);
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
